eth_echo_responder: RTL and testbench

// - Byte-level frame consumer/producer on the i_clk side of the MAC wrapper.
// - Pops frames from the RX FIFO interface (rx_data/rx_ready/rx_req) and buffers the payload.
// - Answers on the TX FIFO interface (tx_data/tx_ready/tx_valid) with a sequence-tagged echo.
// - Used as the link self-test endpoint for the judge ping exchange.
// - Payload format: [LEN][LEN bytes]. Reply format: [LEN+1][SEQ][LEN bytes].

---
 rtl/eth_echo_pkg.sv | 21 ++
 rtl/echo_buf.sv | 28 ++
 rtl/eth_echo_responder.sv | 199 +++++++++++++++++++
 tb/tb_eth_echo_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_echo_pkg.sv
// Shared types and constants for the echo responder.
package eth_echo_pkg;

    localparam int         LEN_W    = 8;
    localparam logic [7:0] SEQ_INIT = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        LEN_REQ,
        LEN_CAP,
        DAT_REQ,
        DAT_CAP,
        DROP_REQ,
        DROP_CAP,
        WAIT_TX,
        TX_HDR,
        TX_SEQ,
        TX_DAT
    } state_t;

endpackage

// File: rtl/echo_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module echo_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port: one byte per cycle when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: data appears one cycle after the address is presented.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_echo_responder.sv
// Link self-test endpoint: pops [LEN][payload] frames from the RX FIFO and
// answers on the TX FIFO with [LEN+1][SEQ][payload].
module eth_echo_responder
    import eth_echo_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_ready,
    output logic        o_rx_req,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [LEN_W-1:0] wptr_reg, wptr_next;
    logic [LEN_W-1:0] rptr_reg, rptr_next;
    logic [7:0]       seq_reg, seq_next;
    logic [TW-1:0]    tmo_reg, tmo_next;
    logic [15:0]      frame_cnt_reg, frame_cnt_next;
    logic [7:0]       err_cnt_reg, err_cnt_next;
    logic             tx_valid_reg, tx_valid_next;
    logic [7:0]       tx_data_reg, tx_data_next;

    logic             rx_req;
    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;
    logic             err_evt;

    echo_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (AW'(wptr_reg)),
        .wr_data (i_rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State, datapath and counter registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            cnt_reg       <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            seq_reg       <= SEQ_INIT;
            tmo_reg       <= '0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            seq_reg       <= seq_next;
            tmo_reg       <= tmo_next;
            frame_cnt_reg <= frame_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            tx_valid_reg  <= tx_valid_next;
            tx_data_reg   <= tx_data_next;
        end
    end

    // Next-state and datapath control; TX bytes are staged one cycle ahead
    // of the output register, so the buffer address leads by one more.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        seq_next       = seq_reg;
        tmo_next       = tmo_reg;
        frame_cnt_next = frame_cnt_reg;
        tx_valid_next  = 1'b0;
        tx_data_next   = '0;
        rx_req         = 1'b0;
        wr_en          = 1'b0;
        rd_addr        = '0;
        err_evt        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_enable && i_rx_ready) begin
                    state_next = LEN_REQ;
                end
            end
            LEN_REQ: begin
                if (i_rx_ready) begin
                    rx_req     = 1'b1;
                    state_next = LEN_CAP;
                end
            end
            LEN_CAP: begin
                len_next = i_rx_data;
                cnt_next = i_rx_data;
                tmo_next = '0;
                if (i_rx_data == '0) begin
                    err_evt    = 1'b1;
                    state_next = IDLE;
                end else if (i_rx_data > MAX_LEN_V) begin
                    err_evt    = 1'b1;
                    state_next = DROP_REQ;
                end else begin
                    wptr_next  = '0;
                    state_next = DAT_REQ;
                end
            end
            DAT_REQ, DROP_REQ: begin
                if (i_rx_ready) begin
                    rx_req     = 1'b1;
                    tmo_next   = '0;
                    state_next = (state_reg == DAT_REQ) ? DAT_CAP : DROP_CAP;
                end else if (tmo_reg == TMO_LAST) begin
                    err_evt    = 1'b1;
                    tmo_next   = '0;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            DAT_CAP: begin
                wr_en      = 1'b1;
                wptr_next  = wptr_reg + 1'b1;
                cnt_next   = cnt_reg - 1'b1;
                state_next = (cnt_reg == 8'd1) ? WAIT_TX : DAT_REQ;
            end
            DROP_CAP: begin
                cnt_next   = cnt_reg - 1'b1;
                state_next = (cnt_reg == 8'd1) ? IDLE : DROP_REQ;
            end
            WAIT_TX: begin
                if (i_tx_ready) begin
                    state_next = TX_HDR;
                end
            end
            TX_HDR: begin
                tx_valid_next = 1'b1;
                tx_data_next  = len_reg + 1'b1;
                state_next    = TX_SEQ;
            end
            TX_SEQ: begin
                tx_valid_next = 1'b1;
                tx_data_next  = seq_reg;
                rd_addr       = '0;
                rptr_next     = '0;
                state_next    = TX_DAT;
            end
            TX_DAT: begin
                tx_valid_next = 1'b1;
                tx_data_next  = rd_data;
                rd_addr       = AW'(rptr_reg + 1'b1);
                rptr_next     = rptr_reg + 1'b1;
                if (rptr_reg == len_reg - 1'b1) begin
                    seq_next       = seq_reg + 1'b1;
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        err_cnt_next = err_cnt_reg;
        if (err_evt && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    assign o_rx_req    = rx_req;
    assign o_tx_valid  = tx_valid_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_busy      = (state_reg != IDLE);
    assign o_frame_cnt = frame_cnt_reg;
    assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_eth_echo_responder.sv
// Scoreboard bench for eth_echo_responder: RX FIFO model, reference reply
// model, and an independent TX monitor.
module tb_eth_echo_responder;

    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_req;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    bit          rand_tx = 1'b0;
    bit          rnd_tx = 1'b0;
    bit          tx_want = 1'b1;
    bit          rand_stall = 1'b0;

    assign tx_ready = rand_tx ? rnd_tx : tx_want;

    int          compared = 0;
    int          mismatched = 0;
    int          pops = 0;
    int          run_len = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          len_q[$];
    logic [7:0]  fb[$];

    logic [7:0]  seq_model = 8'h00;
    logic [15:0] frame_model = 16'h0000;
    int          err_model = 0;

    bit          req_seen;
    bit          prev_req = 1'b0;
    logic [7:0]  mon_e;

    always #5 clk = ~clk;

    eth_echo_responder #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_rx_data   (rx_data),
        .i_rx_ready  (rx_ready),
        .o_rx_req    (rx_req),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_frame_cnt (frame_cnt),
        .o_err_cnt   (err_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a frame is queued on the RX side and its reply (if any)
    // is derived from the frame rules directly.
    task automatic push_frame();
        int len;
        len = int'(fb[0]);
        foreach (fb[i]) rx_q.push_back(fb[i]);
        if (len == 0 || len > MAX_LEN) begin
            if (err_model != 255) err_model++;
        end else begin
            exp_q.push_back(8'(len + 1));
            exp_q.push_back(seq_model);
            for (int i = 1; i <= len; i++) exp_q.push_back(fb[i]);
            len_q.push_back(len + 2);
            seq_model = seq_model + 8'd1;
            frame_model = frame_model + 16'd1;
        end
    endtask

    task automatic make_frame(input int len);
        fb.delete();
        fb.push_back(8'(len));
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < budget) begin
            tick(1);
            n++;
            if (rx_q.size() == 0 && !busy && !tx_valid && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("wait_idle_timeout", n, -1);
    endtask

    // RX FIFO model: pop on each sampled request; data valid the next cycle.
    initial begin : rx_fifo
        forever begin
            @(negedge clk);
            req_seen = rx_req;
            if (req_seen) begin
                check("rx_req_back_to_back", int'(prev_req), 0);
                check("rx_req_needs_ready", int'(rx_ready), 1);
            end
            prev_req = req_seen;
            @(posedge clk);
            #1;
            if (req_seen && rx_q.size() != 0) begin
                rx_data = rx_q.pop_front();
                pops++;
            end
            rx_ready = (rx_q.size() != 0) && !(rand_stall && ($urandom_range(0, 3) == 0));
            rnd_tx = ($urandom_range(0, 2) != 0);
        end
    end

    // TX monitor: compare each written byte and the length of each burst.
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid) begin
                    run_len++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL tx_unexpected: got byte 0x%0h with no reply pending at %0t", tx_data, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("tx_byte", int'(tx_data), int'(mon_e));
                    end
                end else if (run_len != 0) begin
                    if (len_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL tx_burst: got burst of %0d with none expected", run_len);
                    end else begin
                        check("tx_burst_len", run_len, len_q.pop_front());
                    end
                    run_len = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p0;
        int lat;
        int n;

        tick(3);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_rx_req", int'(rx_req), 0);
        rst = 1'b0;
        tick(2);

        // Basic echo
        p0 = pops;
        fb = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
        push_frame();
        wait_idle(500);
        check("basic_pops", pops - p0, 4);
        check("basic_frame_cnt", int'(frame_cnt), int'(frame_model));

        // Two back-to-back frames, SEQ advancing
        fb = '{8'h01, 8'h11};
        push_frame();
        fb = '{8'h01, 8'h22};
        push_frame();
        wait_idle(500);
        check("two_frame_cnt", int'(frame_cnt), int'(frame_model));

        // Zero length frame
        p0 = pops;
        fb = '{8'h00};
        push_frame();
        wait_idle(200);
        check("zero_len_pops", pops - p0, 1);
        check("zero_len_err", int'(err_cnt), err_model);
        fb = '{8'h01, 8'h55};
        push_frame();
        wait_idle(200);

        // Oversize frame drained and dropped
        p0 = pops;
        make_frame(200);
        push_frame();
        wait_idle(2000);
        check("drop_pops", pops - p0, 201);
        check("drop_err", int'(err_cnt), err_model);
        fb = '{8'h01, 8'h7E};
        push_frame();
        wait_idle(200);

        // Disabled: nothing is popped
        enable = 1'b0;
        p0 = pops;
        fb = '{8'h01, 8'h33};
        push_frame();
        tick(20);
        check("disabled_pops", pops - p0, 0);
        check("disabled_busy", int'(busy), 0);
        enable = 1'b1;
        wait_idle(200);

        // Mid-frame RX starvation -> abort
        rx_q.push_back(8'h05);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        err_model++;
        tick(4000);
        check("timeout_still_busy", int'(busy), 1);
        wait_idle(400);
        check("timeout_err", int'(err_cnt), err_model);
        check("timeout_frame_cnt", int'(frame_cnt), int'(frame_model));

        // TX backpressure before the reply, then exact latency
        tx_want = 1'b0;
        fb = '{8'h02, 8'hA5, 8'h5A};
        push_frame();
        tick(140);
        check("hold_no_valid", int'(tx_valid), 0);
        check("hold_busy", int'(busy), 1);
        tx_want = 1'b1;
        lat = 0;
        while (!tx_valid && lat < 10) begin
            tick(1);
            lat++;
        end
        check("tx_latency", lat, 2);
        wait_idle(200);

        // 257 one-byte frames: SEQ wraps to 00
        for (int i = 0; i < 257; i++) begin
            fb = '{8'h01, 8'(i)};
            push_frame();
        end
        wait_idle(20000);
        check("wrap_frame_cnt", int'(frame_cnt), int'(frame_model));

        // Randomised frames with RX stalls and TX-ready jitter
        rand_stall = 1'b1;
        rand_tx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 9);
            if (n == 0) make_frame(0);
            else if (n == 1) make_frame($urandom_range(MAX_LEN + 1, 80));
            else make_frame($urandom_range(1, MAX_LEN));
            push_frame();
        end
        wait_idle(40000);
        rand_stall = 1'b0;
        rand_tx = 1'b0;
        check("rand_frame_cnt", int'(frame_cnt), int'(frame_model));
        check("rand_err_cnt", int'(err_cnt), err_model);

        // Reset in the middle of the payload
        fb = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_frame();
        n = 0;
        while (!tx_valid && n < 200) begin
            tick(1);
            n++;
        end
        check("midtx_started", int'(tx_valid), 1);
        tick(3);
        rst = 1'b1;
        rx_q.delete();
        exp_q.delete();
        len_q.delete();
        run_len = 0;
        seq_model = 8'h00;
        frame_model = 16'h0000;
        err_model = 0;
        #1;
        check("midtx_rst_valid", int'(tx_valid), 0);
        check("midtx_rst_data", int'(tx_data), 0);
        check("midtx_rst_busy", int'(busy), 0);
        check("midtx_rst_frame_cnt", int'(frame_cnt), 0);
        check("midtx_rst_err_cnt", int'(err_cnt), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        fb = '{8'h01, 8'h55};
        push_frame();
        wait_idle(200);
        check("after_rst_frame_cnt", int'(frame_cnt), int'(frame_model));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
